lsu_rmw: RTL and testbench

- Load/store unit sitting directly upstream of the data memory (d_memory); it converts CPU byte/half/word requests into word-wide memory accesses.
- Loads: issues a word read, then extracts and sign- or zero-extends the addressed lane.
- Sub-word stores: read-modify-write (read word, merge lane, write word); word stores write directly.
- One outstanding request; simple valid/ready request side, single-cycle response pulse.

---
 rtl/lsu_pkg.sv | 37 +++
 rtl/lsu_lane_align.sv | 55 +++++
 rtl/lsu_rmw.sv | 177 +++++++++++++++++
 tb/tb_lsu_rmw.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and byte-lane masks.
package lsu_pkg;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD,
      ST_CAP,
      ST_WR,
      ST_RESP
   } state_t;

   // Size 3 is reserved and behaves exactly like a word access.
   function automatic logic [3:0] laneMask(input logic [1:0] size, input logic [1:0] addr);
      logic [3:0] mask;
      case (size)
         SZ_BYTE: mask = 4'b0001 << addr;
         SZ_HALF: mask = addr[1] ? 4'b1100 : 4'b0011;
         default: mask = 4'b1111;
      endcase
      return mask;
   endfunction

   function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] addr);
      logic bad;
      case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = addr[0];
         default: bad = (addr != 2'b00);
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: extracts/extends a load lane and merges store data into a read word.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  addr_i,
   input  logic [1:0]  size_i,
   input  logic        unsigned_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] load_o,
   output logic [31:0] merge_o
);

   logic [7:0]  byteSel;
   logic [15:0] halfSel;
   logic [31:0] repl;
   logic [3:0]  mask;
   logic        signBit;

   always_comb begin
      case (addr_i)
         2'd0:    byteSel = word_i[7:0];
         2'd1:    byteSel = word_i[15:8];
         2'd2:    byteSel = word_i[23:16];
         default: byteSel = word_i[31:24];
      endcase
      halfSel = addr_i[1] ? word_i[31:16] : word_i[15:0];
      mask    = laneMask(size_i, addr_i);
      signBit = 1'b0;
      load_o  = word_i;
      repl    = wdata_i;
      // Store data is replicated across every lane so the mask alone picks the destination.
      case (size_i)
         SZ_BYTE: begin
            signBit = ~unsigned_i & byteSel[7];
            load_o  = {{24{signBit}}, byteSel};
            repl    = {4{wdata_i[7:0]}};
         end
         SZ_HALF: begin
            signBit = ~unsigned_i & halfSel[15];
            load_o  = {{16{signBit}}, halfSel};
            repl    = {2{wdata_i[15:0]}};
         end
         default: begin
            load_o = word_i;
            repl   = wdata_i;
         end
      endcase
      merge_o = word_i;
      for (int i = 0; i < 4; i++) begin
         merge_o[8*i +: 8] = mask[i] ? repl[8*i +: 8] : word_i[8*i +: 8];
      end
   end

endmodule

// File: rtl/lsu_rmw.sv
// Load/store unit in front of d_memory: word-wide reads, lane extraction, read-modify-write for sub-word stores.
// Optional misalignment checking is enabled by defining LSU_MISALIGN_CHK_EN.
module lsu_rmw
   import lsu_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  resp_err,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   state_t                state_q, state_d;
   logic                  we_q, we_d;
   logic [1:0]            size_q, size_d;
   logic                  unsigned_q, unsigned_d;
   logic [1:0]            lane_q, lane_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                  req_ready_q, req_ready_d;
   logic                  resp_valid_q, resp_valid_d;
   logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
   logic                  resp_err_q, resp_err_d;
   logic                  mem_read_q, mem_read_d;
   logic                  mem_write_q, mem_write_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

   logic [DATA_WIDTH-1:0] loadWord;
   logic [DATA_WIDTH-1:0] mergeWord;

   lsu_lane_align u_align (
      .word_i     (mem_rdata),
      .addr_i     (lane_q),
      .size_i     (size_q),
      .unsigned_i (unsigned_q),
      .wdata_i    (wdata_q),
      .load_o     (loadWord),
      .merge_o    (mergeWord)
   );

   always_comb begin
      state_d      = state_q;
      we_d         = we_q;
      size_d       = size_q;
      unsigned_d   = unsigned_q;
      lane_d       = lane_q;
      wdata_d      = wdata_q;
      req_ready_d  = req_ready_q;
      resp_valid_d = 1'b0;
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = resp_err_q;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid && req_ready_q) begin
               we_d         = req_we;
               size_d       = req_size;
               unsigned_d   = req_unsigned;
               lane_d       = req_addr[1:0];
               wdata_d      = req_wdata;
               req_ready_d  = 1'b0;
               resp_rdata_d = '0;
               resp_err_d   = 1'b0;
               mem_addr_d   = {req_addr[ADDR_WIDTH-1:2], 2'b00};
`ifdef LSU_MISALIGN_CHK_EN
               if (isMisaligned(req_size, req_addr[1:0])) begin
                  state_d      = ST_RESP;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
               end else
`endif
               // Full-word stores skip the read phase entirely.
               if (req_we && req_size[1]) begin
                  state_d     = ST_WR;
                  mem_write_d = 1'b1;
                  mem_wdata_d = req_wdata;
               end else begin
                  state_d    = ST_RD;
                  mem_read_d = 1'b1;
               end
            end
         end
         ST_RD: begin
            state_d = ST_CAP;
         end
         ST_CAP: begin
            if (we_q) begin
               state_d     = ST_WR;
               mem_write_d = 1'b1;
               mem_wdata_d = mergeWord;
            end else begin
               state_d      = ST_RESP;
               resp_valid_d = 1'b1;
               resp_rdata_d = loadWord;
            end
         end
         ST_WR: begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_rdata_d = '0;
         end
         ST_RESP: begin
            state_d      = ST_IDLE;
            req_ready_d  = 1'b1;
            resp_rdata_d = '0;
            resp_err_d   = 1'b0;
         end
         default: begin
            state_d     = ST_IDLE;
            req_ready_d = 1'b1;
         end
      endcase
   end

   // Asynchronous reset drops any in-flight write on the spot.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         we_q         <= 1'b0;
         size_q       <= SZ_BYTE;
         unsigned_q   <= 1'b0;
         lane_q       <= 2'b00;
         wdata_q      <= '0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         we_q         <= we_d;
         size_q       <= size_d;
         unsigned_q   <= unsigned_d;
         lane_q       <= lane_d;
         wdata_q      <= wdata_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
      end
   end

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;
   assign mem_read   = mem_read_q;
   assign mem_write  = mem_write_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_lsu_rmw.sv
// Self-checking bench for lsu_rmw: directed cases plus random traffic against a word-array reference model.
module tb_lsu_rmw;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'd0;
   logic        req_unsigned = 1'b0;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = 32'd0;

   logic [31:0] envMem [64];
   logic [31:0] refMem [64];

   int checks = 0;
   int errors = 0;

   lsu_rmw #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_rdata   (resp_rdata),
      .resp_err     (resp_err),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata)
   );

   always #5 clk = ~clk;

   // d_memory stand-in: registered read data, write on the edge where mem_write is high
   always @(posedge clk) begin
      if (mem_read) mem_rdata <= envMem[mem_addr[7:2]];
      if (mem_write) envMem[mem_addr[7:2]] <= mem_wdata;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
      end
   endtask

   always @(negedge clk) begin
      if (reset_n) checkOutput("rdwrExcl", {31'b0, mem_read & mem_write}, 32'd0);
   end

   function automatic logic [31:0] expLoad(input logic [31:0] w, input logic [1:0] sz, input logic uns, input logic [7:0] a);
      logic [31:0] v;
      if (sz == 2'd0) begin
         v = (w >> (8 * a[1:0])) & 32'hFF;
         if (!uns && v >= 32'd128) v = v + 32'hFFFF_FF00;
      end else if (sz == 2'd1) begin
         v = (w >> (16 * a[1])) & 32'hFFFF;
         if (!uns && v >= 32'd32768) v = v + 32'hFFFF_0000;
      end else begin
         v = w;
      end
      return v;
   endfunction

   function automatic logic [31:0] expStore(input logic [31:0] w, input logic [1:0] sz, input logic [7:0] a, input logic [31:0] d);
      int sh;
      if (sz == 2'd0) begin
         sh = 8 * a[1:0];
         return (w & ~(32'hFF << sh)) | ((d & 32'hFF) << sh);
      end else if (sz == 2'd1) begin
         sh = 16 * a[1];
         return (w & ~(32'hFFFF << sh)) | ((d & 32'hFFFF) << sh);
      end
      return d;
   endfunction

   function automatic bit expMisaligned(input logic [1:0] sz, input logic [7:0] a);
`ifdef LSU_MISALIGN_CHK_EN
      return (sz == 2'd1 && a[0]) || (sz >= 2'd2 && a[1:0] != 2'd0);
`else
      return (sz == 2'd3) && (a == 8'hFF) && 1'b0;
`endif
   endfunction

   task automatic waitReady();
      for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
      checkOutput("readyWait", {31'b0, req_ready}, 32'd1);
   endtask

   task automatic applyStimulus(input logic we, input logic [1:0] sz, input logic uns, input logic [7:0] addr, input logic [31:0] wdata);
      int idx = int'(addr[7:2]);
      int expLat, expReads, expWrites, lat, reads, writes, wrAt;
      logic [31:0] expData, expWord, wrData, wrAddr, rdAddr;
      bit misal = expMisaligned(sz, addr);
      expData = 32'd0;
      expWord = refMem[idx];
      if (misal) begin
         expLat = 1; expReads = 0; expWrites = 0;
      end else if (!we) begin
         expLat = 3; expReads = 1; expWrites = 0;
         expData = expLoad(refMem[idx], sz, uns, addr);
      end else if (sz >= 2'd2) begin
         expLat = 2; expReads = 0; expWrites = 1;
         expWord = wdata;
      end else begin
         expLat = 4; expReads = 1; expWrites = 1;
         expWord = expStore(refMem[idx], sz, addr, wdata);
      end
      @(negedge clk);
      waitReady();
      req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
      req_addr = {24'd0, addr}; req_wdata = wdata;
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 0; reads = 0; writes = 0; wrAt = 0;
      wrData = 32'd0; wrAddr = 32'd0; rdAddr = 32'd0;
      while (lat < 8) begin
         @(negedge clk);
         lat++;
         if (mem_read) begin reads++; rdAddr = mem_addr; end
         if (mem_write) begin writes++; wrAt = lat; wrData = mem_wdata; wrAddr = mem_addr; end
         if (resp_valid) break;
      end
      checkOutput("latency", lat, expLat);
      checkOutput("rdata", resp_rdata, expData);
      checkOutput("err", {31'b0, resp_err}, {31'b0, misal});
      checkOutput("reads", reads, expReads);
      checkOutput("writes", writes, expWrites);
      if (expReads == 1) checkOutput("rdAddr", rdAddr, {24'd0, addr[7:2], 2'b00});
      if (expWrites == 1) begin
         checkOutput("wrData", wrData, expWord);
         checkOutput("wrAddr", wrAddr, {24'd0, addr[7:2], 2'b00});
         checkOutput("wrCycle", wrAt, expLat - 1);
         refMem[idx] = expWord;
      end
   endtask

   task automatic setWord(input int idx, input logic [31:0] v);
      envMem[idx] = v;
      refMem[idx] = v;
   endtask

   initial begin
      int respAt[$];
      int sawWr;
      for (int i = 0; i < 64; i++) setWord(i, $urandom);
      setWord(32'h10 >> 2, 32'h8000_00F0);
      setWord(32'h30 >> 2, 32'h1122_3344);
      #12;
      checkOutput("rstReady", {31'b0, req_ready}, 32'd1);
      checkOutput("rstResp", {30'b0, resp_valid, resp_err}, 32'd0);
      checkOutput("rstRdata", resp_rdata, 32'd0);
      checkOutput("rstMemCtl", {30'b0, mem_read, mem_write}, 32'd0);
      checkOutput("rstMemAddr", mem_addr, 32'd0);
      checkOutput("rstMemWdata", mem_wdata, 32'd0);
      @(negedge clk) reset_n = 1'b1;

      $display("[TB] directed loads and stores");
      applyStimulus(1'b0, 2'd0, 1'b1, 8'h10, 32'd0);
      applyStimulus(1'b0, 2'd1, 1'b0, 8'h12, 32'd0);
      applyStimulus(1'b1, 2'd0, 1'b0, 8'h31, 32'h0000_00AB);
      applyStimulus(1'b1, 2'd2, 1'b0, 8'h20, 32'hDEAD_BEEF);
      applyStimulus(1'b0, 2'd2, 1'b0, 8'h20, 32'd0);
      applyStimulus(1'b0, 2'd2, 1'b0, 8'h22, 32'd0);
      applyStimulus(1'b1, 2'd1, 1'b0, 8'h33, 32'h0000_5A5A);
      applyStimulus(1'b0, 2'd3, 1'b1, 8'h30, 32'd0);

      $display("[TB] back-to-back held request");
      @(negedge clk);
      waitReady();
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
      req_addr = 32'h10; req_wdata = 32'd0;
      for (int c = 0; c < 24; c++) begin
         @(negedge clk);
         if (resp_valid) begin
            respAt.push_back(c);
            checkOutput("b2bData", resp_rdata, refMem[4]);
         end
      end
      req_valid = 1'b0;
      checkOutput("b2bCount", respAt.size(), 6);
      for (int i = 1; i < respAt.size(); i++) checkOutput("b2bGap", respAt[i] - respAt[i-1], 4);
      repeat (8) @(negedge clk);

      $display("[TB] random traffic");
      for (int n = 0; n < 80; n++) begin
         applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                       8'($urandom_range(0, 255)), $urandom);
      end

      $display("[TB] reset during write");
      @(negedge clk);
      waitReady();
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_addr = 32'h45; req_wdata = 32'h0000_0077;
      @(posedge clk);
      #1 req_valid = 1'b0;
      sawWr = 0;
      for (int i = 0; i < 6 && sawWr == 0; i++) begin
         @(negedge clk);
         if (mem_write) sawWr = 1;
      end
      checkOutput("rstSawWr", sawWr, 1);
      reset_n = 1'b0;
      #1;
      checkOutput("rstAbortWr", {31'b0, mem_write}, 32'd0);
      checkOutput("rstAbortReady", {31'b0, req_ready}, 32'd1);
      @(negedge clk) reset_n = 1'b1;
      @(negedge clk);
      checkOutput("rstMemKept", envMem[32'h44 >> 2], refMem[32'h44 >> 2]);
      checkOutput("rstReadyAfter", {31'b0, req_ready}, 32'd1);
      applyStimulus(1'b0, 2'd2, 1'b0, 8'h44, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
